// File: rtl/dual_port_ram_pkg.sv
// Shared constants and types for the Buceros dual-port data RAM.
// Holds the default geometry, the clear-engine state type and width helpers.
package dual_port_ram_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16384;
  localparam int DEF_ADDR_WIDTH = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_t;

  // Byte-select width for a given word width.
  function automatic int sel_width(input int dw);
    return dw / 8;
  endfunction

  // Index width; a single-word array still needs a one-bit pointer.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dual_port_ram_clear_fsm.sv
// Post-reset clear engine: walks clr_ptr over the array once, then parks in RUN.
//   state | meaning
//   CLEAR | zeroing word clr_ptr this cycle; requests ignored
//   RUN   | array usable; terminal
module dual_port_ram_clear_fsm
  import dual_port_ram_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int IDX_W          = idx_width(DEF_DEPTH),
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             busy,
  output logic [IDX_W-1:0] clr_ptr
);

  localparam clr_state_t       ENTRY    = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  clr_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ENTRY;
      clr_ptr <= '0;
      busy    <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        CLEAR: begin
          if (clr_ptr == LAST_IDX) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dual_port_ram.sv
// Dual-port synchronous RAM: port A read-only fetch, port B byte-masked read/write.
// One-cycle registered responses; B writes bypass to a same-index A read.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        busy_o,
  input  logic                        a_req_i,
  input  logic [ADDR_WIDTH-1:0]       a_addr_i,
  output logic                        a_valid_o,
  output logic [DATA_WIDTH-1:0]       a_rdata_o,
  output logic                        a_err_o,
  input  logic                        b_req_i,
  input  logic                        b_we_i,
  input  logic [ADDR_WIDTH-1:0]       b_addr_i,
  input  logic [DATA_WIDTH-1:0]       b_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]     b_sel_i,
  output logic                        b_valid_o,
  output logic [DATA_WIDTH-1:0]       b_rdata_o,
  output logic                        b_err_o
);

  localparam int NBYTES = sel_width(DATA_WIDTH);
  localparam int OFS_W  = $clog2(NBYTES);
  localparam int IDX_W  = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             busy;
  logic [IDX_W-1:0] clr_ptr;

  dual_port_ram_clear_fsm #(
    .DEPTH          (DEPTH),
    .IDX_W          (IDX_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy),
    .clr_ptr (clr_ptr)
  );

  assign busy_o = busy;

  logic [IDX_W-1:0]      a_idx, b_idx;
  logic                  a_ok, b_ok;
  logic                  a_acc, b_acc, b_wr;
  logic [DATA_WIDTH-1:0] a_old, b_old, b_merged, a_data;

  assign a_idx = a_addr_i[OFS_W +: IDX_W];
  assign b_idx = b_addr_i[OFS_W +: IDX_W];

  // Any address bit above the index field, or an index past the last word, is out of range.
  assign a_ok = ((a_addr_i >> (OFS_W + IDX_W)) == '0) && (a_idx <= LAST_IDX);
  assign b_ok = ((b_addr_i >> (OFS_W + IDX_W)) == '0) && (b_idx <= LAST_IDX);

  assign a_acc = a_req_i && !busy;
  assign b_acc = b_req_i && !busy;
  assign b_wr  = b_acc && b_we_i && b_ok;

  assign a_old = a_ok ? mem[a_idx] : '0;
  assign b_old = b_ok ? mem[b_idx] : '0;

  always_comb begin
    b_merged = b_old;
    for (int k = 0; k < NBYTES; k++) begin
      if (b_we_i && b_sel_i[k]) begin
        b_merged[8*k +: 8] = b_wdata_i[8*k +: 8];
      end
    end
  end

  assign a_data = (b_wr && (a_idx == b_idx)) ? b_merged : a_old;

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_ptr] <= '0;
    end else if (b_wr) begin
      mem[b_idx] <= b_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_o <= 1'b0;
      a_err_o   <= 1'b0;
      a_rdata_o <= '0;
      b_valid_o <= 1'b0;
      b_err_o   <= 1'b0;
      b_rdata_o <= '0;
    end else begin
      a_valid_o <= a_acc;
      a_err_o   <= a_acc && !a_ok;
      b_valid_o <= b_acc;
      b_err_o   <= b_acc && !b_ok;
      if (a_acc) begin
        a_rdata_o <= a_ok ? a_data : '0;
      end
      if (b_acc) begin
        b_rdata_o <= b_ok ? b_merged : '0;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: DEPTH=16 instance scored through per-port queues,
// DEPTH=12 instance on the same stimulus for the index >= DEPTH cases.
module tb_dual_port_ram;

  logic        clk;
  logic        rst_n;
  logic        a_req, b_req, b_we;
  logic [31:0] a_addr, b_addr, b_wdata;
  logic [3:0]  b_sel;

  logic        busy16, a_valid16, a_err16, b_valid16, b_err16;
  logic [31:0] a_rdata16, b_rdata16;
  logic        busy12, a_valid12, a_err12, b_valid12, b_err12;
  logic [31:0] a_rdata12, b_rdata12;

  dual_port_ram #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .busy_o(busy16),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_valid_o(a_valid16), .a_rdata_o(a_rdata16), .a_err_o(a_err16),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_sel_i(b_sel),
    .b_valid_o(b_valid16), .b_rdata_o(b_rdata16), .b_err_o(b_err16)
  );

  dual_port_ram #(.DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .busy_o(busy12),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_valid_o(a_valid12), .a_rdata_o(a_rdata12), .a_err_o(a_err12),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_sel_i(b_sel),
    .b_valid_o(b_valid12), .b_rdata_o(b_rdata12), .b_err_o(b_err12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        a_req;
    logic [31:0] a_addr;
    logic        b_req;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_sel;
    logic [31:0] a_exp;
    logic        a_err;
    logic [31:0] b_exp;
    logic        b_err;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every response from the DEPTH=16 instance must match the oldest expectation.
  always @(negedge clk) begin
    if (a_valid16) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL a_unexpected_valid: got data %h with no request outstanding", a_rdata16);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rdata", a_rdata16, e.data);
        chk("a_err", 32'(a_err16), 32'(e.err));
      end
    end
    if (b_valid16) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b_unexpected_valid: got data %h with no request outstanding", b_rdata16);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rdata", b_rdata16, e.data);
        chk("b_err", 32'(b_err16), 32'(e.err));
      end
    end
  end

  task automatic idle();
    a_req = 0; a_addr = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_sel = '0;
  endtask

  // Called on a negedge with rst_n low; returns on the first negedge where busy16 is low.
  task automatic clear_phase(input bit probe);
    int  cnt   = 0;
    int  cnt12 = 0;
    bit  done  = 0;
    rst_n = 1;
    if (probe) begin
      a_req  = 1;
      a_addr = 32'h3C;
    end
    while (!done && cnt < 100) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (probe && cnt == 1) begin
        chk("busy_probe_no_valid", 32'(a_valid16), 32'd0);
        a_req = 0;
      end
      if (cnt12 == 0 && !busy12) cnt12 = cnt;
      if (!busy16) done = 1;
    end
    chk("busy16_cycles", 32'(cnt), 32'd16);
    chk("busy12_cycles", 32'(cnt12), 32'd12);
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = '{1, 32'h3C,        0, 0, 32'h0,  32'h0,        4'h0, 32'h0,        0, 32'h0,        0};
    vt[1]  = '{0, 32'h0,         1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        0, 32'hDEADBEEF, 0};
    vt[2]  = '{0, 32'h0,         1, 1, 32'h10, 32'h000000AA, 4'h1, 32'h0,        0, 32'hDEADBEAA, 0};
    vt[3]  = '{1, 32'h13,        1, 0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 0, 32'hDEADBEAA, 0};
    vt[4]  = '{1, 32'h20,        1, 1, 32'h20, 32'h12345678, 4'hF, 32'h12345678, 0, 32'h12345678, 0};
    vt[5]  = '{0, 32'h0,         1, 1, 32'h0,  32'h11111111, 4'hF, 32'h0,        0, 32'h11111111, 0};
    vt[6]  = '{0, 32'h0,         1, 1, 32'h4,  32'h22222222, 4'hF, 32'h0,        0, 32'h22222222, 0};
    vt[7]  = '{0, 32'h0,         1, 1, 32'h8,  32'hFFFF3333, 4'h3, 32'h0,        0, 32'h00003333, 0};
    vt[8]  = '{1, 32'h0,         1, 0, 32'h20, 32'h0,        4'h0, 32'h11111111, 0, 32'h12345678, 0};
    vt[9]  = '{1, 32'h4,         1, 1, 32'h8,  32'hFFFFFFFF, 4'h0, 32'h22222222, 0, 32'h00003333, 0};
    vt[10] = '{1, 32'h8,         1, 0, 32'h40, 32'h0,        4'h0, 32'h00003333, 0, 32'h0,        1};
    vt[11] = '{1, 32'h0010_0000, 1, 1, 32'h44, 32'hCAFEF00D, 4'hF, 32'h0,        1, 32'h0,        1};
    vt[12] = '{1, 32'h4,         1, 0, 32'h8,  32'h0,        4'h0, 32'h22222222, 0, 32'h00003333, 0};

    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_a_valid", 32'(a_valid16), 32'd0);
    chk("rst_b_valid", 32'(b_valid16), 32'd0);
    chk("rst_a_err", 32'(a_err16), 32'd0);
    chk("rst_b_err", 32'(b_err16), 32'd0);
    chk("rst_a_rdata", a_rdata16, 32'd0);
    chk("rst_b_rdata", b_rdata16, 32'd0);
    chk("rst_busy", 32'(busy16), 32'd1);

    clear_phase(1);

    for (int i = 0; i < 13; i++) begin
      a_req = vt[i].a_req; a_addr = vt[i].a_addr;
      b_req = vt[i].b_req; b_we = vt[i].b_we; b_addr = vt[i].b_addr;
      b_wdata = vt[i].b_wdata; b_sel = vt[i].b_sel;
      if (vt[i].a_req) qa.push_back('{vt[i].a_exp, vt[i].a_err});
      if (vt[i].b_req) qb.push_back('{vt[i].b_exp, vt[i].b_err});
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
    chk("table_qa_drained", 32'(qa.size()), 32'd0);
    chk("table_qb_drained", 32'(qb.size()), 32'd0);

    // Index 12 is the first out-of-range word of the DEPTH=12 instance.
    a_req = 1; a_addr = 32'h30;
    qa.push_back('{32'h0, 1'b0});
    @(negedge clk);
    chk("d12_a_valid", 32'(a_valid12), 32'd1);
    chk("d12_a_err", 32'(a_err12), 32'd1);
    chk("d12_a_rdata", a_rdata12, 32'd0);
    idle();
    b_req = 1; b_we = 1; b_addr = 32'h30; b_wdata = 32'h99999999; b_sel = 4'hF;
    qb.push_back('{32'h99999999, 1'b0});
    @(negedge clk);
    chk("d12_b_wr_err", 32'(b_err12), 32'd1);
    chk("d12_b_wr_rdata", b_rdata12, 32'd0);
    idle();
    b_req = 1; b_addr = 32'h0;
    qb.push_back('{32'h11111111, 1'b0});
    @(negedge clk);
    chk("d12_idx0_kept", b_rdata12, 32'h11111111);
    chk("d12_idx0_err", 32'(b_err12), 32'd0);
    idle();
    repeat (2) @(negedge clk);

    // Reset while a B request is still being presented.
    b_req = 1; b_we = 0; b_addr = 32'h10;
    qb.push_back('{32'hDEADBEAA, 1'b0});
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_b_valid", 32'(b_valid16), 32'd0);
    chk("midrst_b_rdata", b_rdata16, 32'd0);
    chk("midrst_a_rdata", a_rdata16, 32'd0);
    chk("midrst_busy", 32'(busy16), 32'd1);
    idle();
    repeat (2) @(negedge clk);
    clear_phase(0);

    b_req = 1; b_addr = 32'h10;
    qb.push_back('{32'h0, 1'b0});
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    chk("final_qa_drained", 32'(qa.size()), 32'd0);
    chk("final_qb_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
